// File: rtl/si570_pkg.sv
// si570_pkg -- shared definitions for the Si-570 frequency calculator.
//
// Holds the FPU opcodes, the Si-570 register field layout, the legal HS_DIV
// values in search order, the controller state encoding, the double-precision
// bit pattern for 2^28 and the step sequencing helper used by the FPU phase.
package si570_pkg;

    // FPU opcodes
    localparam logic [2:0] OP_NONE     = 3'd0;
    localparam logic [2:0] OP_TO_FLOAT = 3'd1;
    localparam logic [2:0] OP_TO_INT   = 3'd2;
    localparam logic [2:0] OP_MUL      = 3'd3;
    localparam logic [2:0] OP_DIV      = 3'd4;

    // Packed register set {HS_DIV_REG, N1_REG, RFREQ}
    localparam int HS_W      = 3;
    localparam int N1_W      = 7;
    localparam int RFREQ_W   = 38;
    localparam int RFREQ_LSB = 0;
    localparam int N1_LSB    = RFREQ_LSB + RFREQ_W;
    localparam int HS_LSB    = N1_LSB + N1_W;
    localparam int REGS_W    = HS_LSB + HS_W;

    // Legal HS_DIV values, index 0 (LSBs) searched first: 11, 9, 7, 6, 5, 4
    localparam int HS_COUNT = 6;
    localparam logic [HS_COUNT*4-1:0] HS_DIV_LIST = {4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11};

    // IEEE-754 double for 2^28 (exponent 1023 + 28)
    localparam logic [63:0] FP_TWO_POW_28 = 64'h41B0_0000_0000_0000;

    // FPU sequence length and the steps that become redundant once the
    // crystal frequency and 2^28 are cached: 1, 2, 4, 6, 7, 8, 10
    localparam logic [3:0]  LAST_STEP   = 4'd13;
    localparam logic [15:0] CACHED_SKIP = 16'h05D6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_ISSUE,
        ST_WAIT
    } calc_state_t;

    function automatic logic [3:0] hs_div_at(input logic [2:0] idx);
        return HS_DIV_LIST[4*int'(idx) +: 4];
    endfunction

    // Next FPU step after cur; with the cache in use, skipped steps are
    // stepped over (at most three in a row, so four probes suffice).
    function automatic logic [3:0] next_step(input logic [3:0] cur, input logic use_cache);
        logic [3:0] s;
        s = cur + 4'd1;
        for (int i = 0; i < 4; i++) begin
            if (use_cache && CACHED_SKIP[s]) begin
                s = s + 4'd1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/si570_divider_search.sv
// si570_divider_search -- finds the HS_DIV/N1 pair giving the lowest legal DCO.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle strobe, samples target (ignored while active)
//   target [31:0]     desired output frequency in Hz
//   done              one-cycle strobe at the end of the search
//   found             a legal pair exists (valid with done)
//   hs_div [3:0]      chosen HS_DIV value (4..11)
//   n1 [7:0]          chosen N1 value (1 or even 2..128)
//
// One candidate per cycle. For each HS_DIV (11,9,7,6,5,4) N1 walks 1,2,4,..,128
// and the pass ends at the first fdco reaching FDCO_MIN_HZ; that fdco is kept
// only if it is within FDCO_MAX_HZ and strictly below the best so far.
module si570_divider_search
    import si570_pkg::*;
#(
    parameter logic [42:0] FDCO_MIN_HZ = 43'd4850000000,
    parameter logic [42:0] FDCO_MAX_HZ = 43'd5670000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [3:0]  hs_div,
    output logic [7:0]  n1
);

    logic        active_reg;
    logic [2:0]  hs_idx_reg;
    logic [7:0]  n1_reg;
    logic [31:0] target_reg;
    logic [42:0] best_fdco_reg;

    logic [3:0]  cand_hs;
    logic [10:0] div_prod;
    logic [42:0] fdco;
    logic        hit;
    logic        better;
    logic        last_n1;
    logic        last_hs;

    always_comb begin
        cand_hs  = hs_div_at(hs_idx_reg);
        div_prod = {7'd0, cand_hs} * {3'd0, n1_reg};
        // 32-bit target times at most 11*128 always fits in 43 bits
        fdco     = {11'd0, target_reg} * {32'd0, div_prod};
        hit      = (fdco >= FDCO_MIN_HZ);
        better   = hit && (fdco <= FDCO_MAX_HZ) && (fdco < best_fdco_reg);
        last_n1  = (n1_reg == 8'd128);
        last_hs  = (hs_idx_reg == 3'(HS_COUNT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_reg    <= 1'b0;
            hs_idx_reg    <= '0;
            n1_reg        <= 8'd1;
            target_reg    <= '0;
            best_fdco_reg <= '1;
            done          <= 1'b0;
            found         <= 1'b0;
            hs_div        <= '0;
            n1            <= '0;
        end else begin
            done <= 1'b0;
            if (!active_reg) begin
                if (start) begin
                    active_reg    <= 1'b1;
                    target_reg    <= target;
                    hs_idx_reg    <= '0;
                    n1_reg        <= 8'd1;
                    best_fdco_reg <= '1;
                    found         <= 1'b0;
                end
            end else begin
                if (better) begin
                    best_fdco_reg <= fdco;
                    found         <= 1'b1;
                    hs_div        <= cand_hs;
                    n1            <= n1_reg;
                end
                if (hit || last_n1) begin
                    n1_reg <= 8'd1;
                    if (last_hs) begin
                        active_reg <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        hs_idx_reg <= hs_idx_reg + 3'd1;
                    end
                end else begin
                    // N1 legal values: 1, then the even numbers up to 128
                    n1_reg <= (n1_reg == 8'd1) ? 8'd2 : n1_reg + 8'd2;
                end
            end
        end
    end

endmodule

// File: rtl/si570_freq_calc.sv
// si570_freq_calc -- computes a full Si-570 register set for a target frequency.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 one-cycle strobe, ignored while busy
//   target_hz [31:0]      desired output frequency (sampled on start)
//   si570_regs_in [47:0]  factory startup {HS_DIV_REG, N1_REG, RFREQ}
//   busy                  high from the cycle after start until done/error
//   done / error          one-cycle completion strobes
//   si570_regs_out [47:0] new {HS_DIV_REG, N1_REG, RFREQ}, held until next done
//   A, B, OP              operands and single-cycle opcode to the shared FPU
//   RESULT, fpu_done      FPU result and completion strobe
//
// Optional build macro SI570_XTAL_CACHE_EN: keeps the crystal frequency and
// float(2^28) after the first successful run; later runs then skip the seven
// FPU steps that only depend on the startup registers and ignore si570_regs_in.
module si570_freq_calc
    import si570_pkg::*;
#(
    parameter logic [31:0] STARTUP_HZ  = 32'd156250000,
    parameter logic [42:0] FDCO_MIN_HZ = 43'd4850000000,
    parameter logic [42:0] FDCO_MAX_HZ = 43'd5670000000,
    parameter int          FRAC_BITS   = 28
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] target_hz,
    input  logic [47:0] si570_regs_in,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [47:0] si570_regs_out,
    output logic [63:0] A,
    output logic [63:0] B,
    output logic [2:0]  OP,
    input  logic [63:0] RESULT,
    input  logic        fpu_done
);

    calc_state_t state_reg;
    logic [3:0]  step_reg;
    logic [31:0] target_reg;
    logic [3:0]  old_hs_reg;
    logic [7:0]  old_n1_reg;
    logic [RFREQ_W-1:0] old_rfreq_reg;
    logic [3:0]  new_hs_reg;
    logic [7:0]  new_n1_reg;
    logic        search_start_reg;

    // Intermediate doubles, named after the value they hold
    logic [63:0] fp_2p28_reg, fp_startup_reg, fp_target_reg, fp_old_prod_reg;
    logic [63:0] fp_new_prod_reg, fp_old_rfreq_reg, fp_old_fdco_reg;
    logic [63:0] fp_new_fdco_reg, fp_xtal_reg, fp_ratio_reg;

    logic        search_done, search_found;
    logic [3:0]  search_hs;
    logic [7:0]  search_n1;
    logic [10:0] old_prod, new_prod;
    logic [2:0]  op_sel;
    logic [63:0] a_sel, b_sel;
    logic        rfreq_ovf;
    logic        use_cache;

    si570_divider_search #(
        .FDCO_MIN_HZ (FDCO_MIN_HZ),
        .FDCO_MAX_HZ (FDCO_MAX_HZ)
    ) u_search (
        .clk    (clk),
        .reset  (reset),
        .start  (search_start_reg),
        .target (target_reg),
        .done   (search_done),
        .found  (search_found),
        .hs_div (search_hs),
        .n1     (search_n1)
    );

    assign old_prod  = {3'd0, old_n1_reg} * {7'd0, old_hs_reg};
    assign new_prod  = {3'd0, new_n1_reg} * {7'd0, new_hs_reg};
    assign rfreq_ovf = |RESULT[63:RFREQ_W];

`ifdef SI570_XTAL_CACHE_EN
    logic cache_valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid_reg <= 1'b0;
        end else if (state_reg == ST_WAIT && fpu_done && step_reg == LAST_STEP && !rfreq_ovf) begin
            cache_valid_reg <= 1'b1;
        end
    end

    assign use_cache = cache_valid_reg;
`else
    assign use_cache = 1'b0;
`endif

    // Operand/opcode selection for the current FPU step
    always_comb begin
        op_sel = OP_NONE;
        a_sel  = '0;
        b_sel  = '0;
        case (step_reg)
            4'd1:  begin op_sel = OP_TO_FLOAT; a_sel = 64'd1 << FRAC_BITS;   end
            4'd2:  begin op_sel = OP_TO_FLOAT; a_sel = 64'(STARTUP_HZ);      end
            4'd3:  begin op_sel = OP_TO_FLOAT; a_sel = 64'(target_reg);      end
            4'd4:  begin op_sel = OP_TO_FLOAT; a_sel = 64'(old_prod);        end
            4'd5:  begin op_sel = OP_TO_FLOAT; a_sel = 64'(new_prod);        end
            4'd6:  begin op_sel = OP_TO_FLOAT; a_sel = 64'(old_rfreq_reg);   end
            4'd7:  begin op_sel = OP_DIV; a_sel = fp_old_rfreq_reg; b_sel = fp_2p28_reg;      end
            4'd8:  begin op_sel = OP_MUL; a_sel = fp_startup_reg;   b_sel = fp_old_prod_reg;  end
            4'd9:  begin op_sel = OP_MUL; a_sel = fp_target_reg;    b_sel = fp_new_prod_reg;  end
            4'd10: begin op_sel = OP_DIV; a_sel = fp_old_fdco_reg;  b_sel = fp_old_rfreq_reg; end
            4'd11: begin op_sel = OP_DIV; a_sel = fp_new_fdco_reg;  b_sel = fp_xtal_reg;      end
            4'd12: begin op_sel = OP_MUL; a_sel = fp_ratio_reg;     b_sel = fp_2p28_reg;      end
            4'd13: begin op_sel = OP_TO_INT; a_sel = fp_ratio_reg;  end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            step_reg         <= '0;
            target_reg       <= '0;
            old_hs_reg       <= '0;
            old_n1_reg       <= '0;
            old_rfreq_reg    <= '0;
            new_hs_reg       <= '0;
            new_n1_reg       <= '0;
            search_start_reg <= 1'b0;
            fp_2p28_reg      <= FP_TWO_POW_28;
            fp_startup_reg   <= '0;
            fp_target_reg    <= '0;
            fp_old_prod_reg  <= '0;
            fp_new_prod_reg  <= '0;
            fp_old_rfreq_reg <= '0;
            fp_old_fdco_reg  <= '0;
            fp_new_fdco_reg  <= '0;
            fp_xtal_reg      <= '0;
            fp_ratio_reg     <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            si570_regs_out   <= '0;
            A                <= '0;
            B                <= '0;
            OP               <= OP_NONE;
        end else begin
            done             <= 1'b0;
            error            <= 1'b0;
            OP               <= OP_NONE;
            search_start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        target_reg       <= target_hz;
                        old_hs_reg       <= {1'b0, si570_regs_in[HS_LSB +: HS_W]} + 4'd4;
                        old_n1_reg       <= {1'b0, si570_regs_in[N1_LSB +: N1_W]} + 8'd1;
                        old_rfreq_reg    <= si570_regs_in[RFREQ_LSB +: RFREQ_W];
                        search_start_reg <= 1'b1;
                        busy             <= 1'b1;
                        state_reg        <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (search_done) begin
                        if (search_found) begin
                            new_hs_reg <= search_hs;
                            new_n1_reg <= search_n1;
                            step_reg   <= next_step(4'd0, use_cache);
                            state_reg  <= ST_ISSUE;
                        end else begin
                            error     <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_ISSUE: begin
                    OP        <= op_sel;
                    A         <= a_sel;
                    B         <= b_sel;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fpu_done) begin
                        case (step_reg)
                            4'd1:  fp_2p28_reg      <= RESULT;
                            4'd2:  fp_startup_reg   <= RESULT;
                            4'd3:  fp_target_reg    <= RESULT;
                            4'd4:  fp_old_prod_reg  <= RESULT;
                            4'd5:  fp_new_prod_reg  <= RESULT;
                            4'd6:  fp_old_rfreq_reg <= RESULT;
                            4'd7:  fp_old_rfreq_reg <= RESULT;  // now RFREQ as a real ratio
                            4'd8:  fp_old_fdco_reg  <= RESULT;
                            4'd9:  fp_new_fdco_reg  <= RESULT;
                            4'd10: fp_xtal_reg      <= RESULT;
                            4'd11: fp_ratio_reg     <= RESULT;
                            4'd12: fp_ratio_reg     <= RESULT;  // scaled by 2^28
                            default: ;
                        endcase
                        if (step_reg == LAST_STEP) begin
                            if (rfreq_ovf) begin
                                error <= 1'b1;
                            end else begin
                                si570_regs_out <= {3'(new_hs_reg - 4'd4), 7'(new_n1_reg - 8'd1),
                                                   RESULT[RFREQ_W-1:0]};
                                done           <= 1'b1;
                            end
                            busy      <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            step_reg  <= next_step(step_reg, use_cache);
                            state_reg <= ST_ISSUE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_si570_freq_calc.sv
// tb_si570_freq_calc -- self-checking bench for si570_freq_calc.
//
// A behavioural double-precision FPU answers the DUT's OP pulses with a random
// latency. Expected register sets come from a reference model that searches
// the legal divider pairs with plain integer arithmetic and evaluates the
// RFREQ formula with reals. Honours SI570_XTAL_CACHE_EN when defined.
`timescale 1ns/1ps
module tb_si570_freq_calc;

    localparam longint FMIN = 64'd4850000000;
    localparam longint FMAX = 64'd5670000000;
    localparam real    TWO28 = 268435456.0;
    localparam logic [47:0] REGS1 = {3'd0, 7'd7, 38'h2BC000000};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] target_hz = '0;
    logic [47:0] si570_regs_in = '0;
    logic        busy, done, error;
    logic [47:0] si570_regs_out;
    logic [63:0] A, B;
    logic [2:0]  OP;
    logic [63:0] RESULT = '0;
    logic        fpu_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int op_count = 0;
    int force_lat = 0;
    logic [47:0] exp_regs_out = '0;
    bit  ref_cache_valid = 0;
    real ref_xtal = 0.0;

    si570_freq_calc dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .target_hz      (target_hz),
        .si570_regs_in  (si570_regs_in),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .si570_regs_out (si570_regs_out),
        .A              (A),
        .B              (B),
        .OP             (OP),
        .RESULT         (RESULT),
        .fpu_done       (fpu_done)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural FPU ----------------
    function automatic logic [63:0] fpu_eval(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'd1:    return $realtobits(real'(a));
            3'd2:    return 64'(longint'($bitstoreal(a)));
            3'd3:    return $realtobits($bitstoreal(a) * $bitstoreal(b));
            3'd4:    return $realtobits($bitstoreal(a) / $bitstoreal(b));
            default: return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    int          fpu_wait = 0;
    logic [2:0]  fpu_op = '0;
    logic [63:0] fpu_a = '0, fpu_b = '0;

    always @(negedge clk) begin
        fpu_done = 1'b0;
        if (fpu_wait > 0) begin
            fpu_wait = fpu_wait - 1;
            if (fpu_wait == 0) begin
                RESULT   = fpu_eval(fpu_op, fpu_a, fpu_b);
                fpu_done = 1'b1;
            end
        end
        if (OP != 3'd0) begin
            op_count = op_count + 1;
            fpu_op   = OP;
            fpu_a    = A;
            fpu_b    = B;
            fpu_wait = (force_lat > 0) ? force_lat : int'($urandom_range(1, 3));
        end
    end

    // ---------------- reference model ----------------
    task automatic ref_calc(input logic [31:0] tgt, input logic [47:0] regs,
                            output bit ok, output logic [47:0] val, output int ops);
        int     hs_list[6] = '{11, 9, 7, 6, 5, 4};
        bit     found = 0;
        longint best = 0, f, q;
        int     bh = 0, bn = 0, old_hs, old_n1;
        bit     cached;
        real    xtal, ratio;
        foreach (hs_list[k]) begin
            for (int n = 1; n <= 128; n = (n == 1) ? 2 : n + 2) begin
                f = longint'(tgt) * hs_list[k] * n;
                if (f >= FMIN) begin
                    if (f <= FMAX && (!found || f < best)) begin
                        found = 1; best = f; bh = hs_list[k]; bn = n;
                    end
                    break;
                end
            end
        end
        ok = 0; val = '0; ops = 0;
        if (!found) return;
`ifdef SI570_XTAL_CACHE_EN
        cached = ref_cache_valid;
`else
        cached = 0;
`endif
        ops = cached ? 6 : 13;
        if (cached) begin
            xtal = ref_xtal;
        end else begin
            old_hs = int'(regs[47:45]) + 4;
            old_n1 = int'(regs[44:38]) + 1;
            xtal = (156250000.0 * real'(old_hs * old_n1)) / (real'(regs[37:0]) / TWO28);
        end
        ratio = (real'(tgt) * real'(bh * bn)) / xtal;
        q = longint'(ratio * TWO28);
        if (q < 0 || q >= (longint'(1) << 38)) return;
        ok = 1;
        val = {3'(bh - 4), 7'(bn - 1), 38'(q)};
        ref_cache_valid = 1;
        ref_xtal = xtal;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ref_cache_valid = 0;
        exp_regs_out = '0;
    endtask

    task automatic run(input string tag, input logic [31:0] tgt, input logic [47:0] regs, input bit poke);
        bit ok, fin;
        logic [47:0] val;
        int exp_ops, ops0, dones, errs;
        ref_calc(tgt, regs, ok, val, exp_ops);
        if (ok) exp_regs_out = val;
        @(negedge clk);
        target_hz = tgt;
        si570_regs_in = regs;
        start = 1'b1;
        ops0 = op_count;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        dones = 0; errs = 0; fin = 0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            if (poke && (i == 3 || i == 40)) begin
                target_hz = 32'd1000000;
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            if (done)  dones++;
            if (error) errs++;
            if (done || error) fin = 1;
        end
        check({tag, "_finished"}, 64'(fin), 64'd1);
        repeat (5) begin
            @(negedge clk);
            if (done)  dones++;
            if (error) errs++;
        end
        check({tag, "_dones"}, 64'(dones), 64'(ok ? 1 : 0));
        check({tag, "_errors"}, 64'(errs), 64'(ok ? 0 : 1));
        check({tag, "_regs_out"}, 64'(si570_regs_out), 64'(exp_regs_out));
        check({tag, "_op_pulses"}, 64'(op_count - ops0), 64'(exp_ops));
        check({tag, "_idle"}, 64'(busy), 64'd0);
        $display("run %s target=%0d regs_in=%h ok=%0d regs_out=%h ops=%0d",
                 tag, tgt, regs, ok, si570_regs_out, op_count - ops0);
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        bit seen;
        int dones, errs;
        logic [31:0] tgt;
        logic [47:0] regs;

        do_reset();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_op", 64'(OP), 64'd0);
        check("rst_regs_out", 64'(si570_regs_out), 64'd0);

        // RFREQ overflow: tiny crystal derived from a huge startup RFREQ
        run("rfreq_overflow", 32'd322265625, {3'd0, 7'd0, 38'(64'd1000 << 28)}, 0);
        run("scn1", 32'd322265625, REGS1, 0);
        check("scn1_exact", 64'(si570_regs_out), 64'({3'd0, 7'd3, 38'h2D1E00000}));
        run("scn2", 32'd100000000, REGS1, 0);
        check("scn2_exact", 64'(si570_regs_out), 64'({3'd1, 7'd9, 38'h2BC000000}));
        run("low_target", 32'd1000000, REGS1, 0);
        run("high_target", 32'd1500000000, REGS1, 0);
        run("zero_target", 32'd0, REGS1, 0);

        // Reset while FPU step 9 (target x new product) is outstanding
        force_lat = 6;
        @(negedge clk);
        target_hz = 32'd322265625;
        si570_regs_in = REGS1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (OP == 3'd3 && A == $realtobits(322265625.0)) seen = 1;
        end
        check("step9_seen", 64'(seen), 64'd1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ref_cache_valid = 0;
        exp_regs_out = '0;
        force_lat = 0;
        dones = 0; errs = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) dones++;
            if (error) errs++;
        end
        check("abort_no_activity", 64'(dones), 64'd0);
        check("abort_no_error", 64'(errs), 64'd0);
        check("abort_regs_out", 64'(si570_regs_out), 64'd0);
        run("scn1_after_abort", 32'd322265625, REGS1, 0);
        check("scn1_after_abort_exact", 64'(si570_regs_out), 64'({3'd0, 7'd3, 38'h2D1E00000}));

        // start strobes while busy must be dropped
        run("start_while_busy", 32'd322265625, REGS1, 1);

`ifdef SI570_XTAL_CACHE_EN
        run("cached_scn2", 32'd100000000, 48'd0, 0);
        check("cached_scn2_exact", 64'(si570_regs_out), 64'({3'd1, 7'd9, 38'h2BC000000}));
`endif

        for (int r = 0; r < 10; r++) begin
            if (r % 4 == 3) tgt = $urandom_range(1, 2000000000);
            else            tgt = $urandom_range(10000000, 300000000);
            regs = {3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                    38'(64'($urandom_range(40, 48)) << 28) | 38'($urandom_range(0, 268435455))};
            run($sformatf("rand%0d", r), tgt, regs, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
